reg_file_pairs: RTL
===================

Name: reg_file_pairs

Overview:
- Parametrised general-purpose register file for the 8080 datapath: B,C,D,E,H,L plus the W,Z temporaries. Generalises the single 8-bit bus register to DATA_W-wide registers grouped in high/low pairs.
- Supports byte and pair writes, pair increment/decrement, and a multi-cycle pair exchange (XCHG) behind a valid/ready handshake.
- Sits between the internal data bus and the address incrementer in the CPU core.

Parameters:
- DATA_W, 8, width of one register in bits.
- NUM_PAIRS, 4, number of register pairs (registers = 2*NUM_PAIRS); pair 0=BC, 1=DE, 2=HL, 3=WZ.

Ports:
- clk50M_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- op_valid_i  in  1  operation request.
- op_ready_o  out  1  block can accept an operation this cycle.
- op_code_i  in  3  0 NOP, 1 WR8, 2 WR16, 3 INC16, 4 DEC16, 5 XCHG; 6-7 treated as NOP.
- op_reg_i  in  $clog2(2*NUM_PAIRS)  register index for WR8.
- op_pair_a_i  in  $clog2(NUM_PAIRS)  target pair for WR16/INC16/DEC16; first pair for XCHG.
- op_pair_b_i  in  $clog2(NUM_PAIRS)  second pair for XCHG.
- wr_data_i  in  2*DATA_W  write data; WR8 uses [DATA_W-1:0].
- rd_reg_i  in  $clog2(2*NUM_PAIRS)  byte read index.
- rd_byte_en_i  in  1  byte read enable.
- rd_byte_o  out  DATA_W  byte read data.
- rd_pair_i  in  $clog2(NUM_PAIRS)  pair read index.
- rd_pair_en_i  in  1  pair read enable.
- rd_pair_o  out  2*DATA_W  pair read data.
- wrap_o  out  1  one-cycle pulse: INC16 wrapped all-ones->0 or DEC16 wrapped 0->all-ones.

Behaviour:
- Reset: all registers 0, FSM IDLE, op_ready_o=1, wrap_o=0. Reset asserted mid-XCHG aborts it; the registers are zeroed.
- Pair p = {reg[2p], reg[2p+1]}: the even index is the high byte.
- Accept: an op is taken on a rising edge when op_valid_i && op_ready_o. Inputs are ignored while op_ready_o=0.
- WR8: reg[op_reg_i] <= wr_data_i[DATA_W-1:0] at the accepting edge.
- WR16: pair[a] <= wr_data_i at the accepting edge.
- INC16/DEC16: pair[a] <= pair[a] ± 1, modulo 2^(2*DATA_W), at the accepting edge. wrap_o is high in the following cycle only on wrap.
- XCHG, a two-state FSM IDLE -> XCHG2 -> IDLE:
  - Accept edge: tmp <= pair[a], pair[a] <= pair[b]; FSM enters XCHG2; op_ready_o=0 during XCHG2.
  - Next edge: pair[b] <= tmp; FSM returns to IDLE.
  - Latency 2 cycles; throughput one XCHG per 2 cycles.
  - a==b leaves the value unchanged but still takes 2 cycles.
- Reads are combinational from stored state with no write bypass. A read in the same cycle as a write returns the old value.
- During XCHG2, pair[a] already holds the new value and pair[b] still holds the old value; reads reflect that.
- op_reg_i and pair indices out of range (non-power-of-two NUM_PAIRS): the op behaves as NOP.

Optional Feature:
- Macro RF_TRISTATE_RD_EN.
- Defined: rd_byte_o and rd_pair_o are high-impedance (all z) when their enable is low, for direct connection to the shared internal bus.
- Undefined: both outputs drive all zeros when disabled, so enabled outputs can be OR-combined. Data when enabled is identical in both builds.

Decomposition:
- Package reg_file_pkg holds:
  - op_code enum (OP_NOP..OP_XCHG);
  - the 8080 pair-index constants PAIR_BC, PAIR_DE, PAIR_HL, PAIR_WZ;
  - the FSM state enum (ST_IDLE, ST_XCHG2).
- One sub-module, pair_incdec: combinational 2*DATA_W ± 1 with a wrap output, parametrised by width.
- Storage, the FSM and the read muxes stay in the top module.

Test Plan:
- Reset, then read all pairs with enables high -> every pair reads 16'h0000; op_ready_o=1. Enables low -> z with RF_TRISTATE_RD_EN defined, 16'h0000 without it.
- WR8 reg2=8'h12, then WR8 reg3=8'h34 -> rd_pair(1)=16'h1234, rd_byte(2)=8'h12. In the same cycle as the first write, rd_byte(2) still shows 8'h00.
- WR16 HL=16'hFFFF, then INC16 HL -> HL=16'h0000 and wrap_o pulses for exactly one cycle. DEC16 HL -> HL=16'hFFFF with a wrap_o pulse. DEC16 from 16'h0001 -> 16'h0000 with no pulse.
- DE=16'hABCD, HL=16'h1234, XCHG(a=DE, b=HL):
  - op_ready_o low for 1 cycle;
  - mid-op DE=16'h1234, HL=16'h1234;
  - final DE=16'h1234, HL=16'hABCD;
  - a second op_valid held during XCHG2 is accepted only after op_ready_o returns high.
- Start XCHG, assert rst_i during XCHG2 -> all registers 0, FSM IDLE, op_ready_o=1 immediately (asynchronous).
- op_code 6 and 7 with op_valid_i high -> no register change, op_ready_o stays 1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types for the 8080 register-pair file: op codes, pair indices, XCHG FSM states.
package reg_file_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WR8   = 3'd1,
    OP_WR16  = 3'd2,
    OP_INC16 = 3'd3,
    OP_DEC16 = 3'd4,
    OP_XCHG  = 3'd5
  } op_code_e;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_WZ = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_XCHG2 = 1'b1
  } state_e;

endpackage

// File: rtl/pair_incdec.sv
// Combinational W-bit +/-1 used for the 16-bit pair increment/decrement; flags modulo wrap.
module pair_incdec #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] result,
  output logic         wrap
);

  always_comb begin
    if (dec) begin
      result = value - W'(1);
      wrap   = (value == '0);
    end else begin
      result = value + W'(1);
      wrap   = (value == '1);
    end
  end

endmodule

// File: rtl/reg_file_pairs.sv
// 8080 register file (BC, DE, HL, WZ) with byte/pair writes, pair inc/dec and two-cycle XCHG.
// Optional build macro RF_TRISTATE_RD_EN: disabled read ports float (z) instead of driving zero.
module reg_file_pairs
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PAIRS = 4,
  localparam int REG_W    = $clog2(2*NUM_PAIRS),
  localparam int PAIR_W   = $clog2(NUM_PAIRS)
) (
  input  logic                clk50M_i,
  input  logic                rst_i,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [2:0]          op_code_i,
  input  logic [REG_W-1:0]    op_reg_i,
  input  logic [PAIR_W-1:0]   op_pair_a_i,
  input  logic [PAIR_W-1:0]   op_pair_b_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  input  logic [REG_W-1:0]    rd_reg_i,
  input  logic                rd_byte_en_i,
  output logic [DATA_W-1:0]   rd_byte_o,
  input  logic [PAIR_W-1:0]   rd_pair_i,
  input  logic                rd_pair_en_i,
  output logic [2*DATA_W-1:0] rd_pair_o,
  output logic                wrap_o
);

  logic [DATA_W-1:0]   regs  [2*NUM_PAIRS];
  logic [2*DATA_W-1:0] pairs [NUM_PAIRS];
  logic [2*DATA_W-1:0] xchg_tmp;
  logic [PAIR_W-1:0]   xchg_b;
  state_e              state, state_n;

  logic                accept, reg_ok, a_ok, b_ok, rd_reg_ok, rd_pair_ok;
  logic [REG_W-1:0]    a_hi, a_lo, b_hi, b_lo, xb_hi, xb_lo;
  logic [2*DATA_W-1:0] pair_a_val, pair_b_val, incdec_val;
  logic                incdec_wrap;
  logic [DATA_W-1:0]   byte_val;
  logic [2*DATA_W-1:0] pair_val;

  // Even register index is the high byte of its pair.
  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pairs
    assign pairs[p] = {regs[2*p], regs[2*p+1]};
  end

  assign op_ready_o = (state == ST_IDLE);
  assign accept     = op_valid_i && op_ready_o;

  assign reg_ok     = int'(op_reg_i)    < 2*NUM_PAIRS;
  assign a_ok       = int'(op_pair_a_i) < NUM_PAIRS;
  assign b_ok       = int'(op_pair_b_i) < NUM_PAIRS;
  assign rd_reg_ok  = int'(rd_reg_i)    < 2*NUM_PAIRS;
  assign rd_pair_ok = int'(rd_pair_i)   < NUM_PAIRS;

  assign a_hi  = {op_pair_a_i, 1'b0};
  assign a_lo  = {op_pair_a_i, 1'b1};
  assign b_hi  = {op_pair_b_i, 1'b0};
  assign b_lo  = {op_pair_b_i, 1'b1};
  assign xb_hi = {xchg_b, 1'b0};
  assign xb_lo = {xchg_b, 1'b1};

  assign pair_a_val = a_ok ? pairs[op_pair_a_i] : '0;
  assign pair_b_val = b_ok ? pairs[op_pair_b_i] : '0;

  pair_incdec #(.W(2*DATA_W)) u_incdec (
    .value  (pair_a_val),
    .dec    (op_code_i == OP_DEC16),
    .result (incdec_val),
    .wrap   (incdec_wrap)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept && op_code_i == OP_XCHG && a_ok && b_ok) state_n = ST_XCHG2;
      ST_XCHG2: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      regs     <= '{default: '0};
      xchg_tmp <= '0;
      xchg_b   <= '0;
      state    <= ST_IDLE;
      wrap_o   <= 1'b0;
    end else begin
      state  <= state_n;
      wrap_o <= 1'b0;
      if (state == ST_XCHG2) begin
        regs[xb_hi] <= xchg_tmp[2*DATA_W-1:DATA_W];
        regs[xb_lo] <= xchg_tmp[DATA_W-1:0];
      end else if (accept) begin
        case (op_code_i)
          OP_WR8: if (reg_ok) regs[op_reg_i] <= wr_data_i[DATA_W-1:0];
          OP_WR16: if (a_ok) begin
            regs[a_hi] <= wr_data_i[2*DATA_W-1:DATA_W];
            regs[a_lo] <= wr_data_i[DATA_W-1:0];
          end
          OP_INC16, OP_DEC16: if (a_ok) begin
            regs[a_hi] <= incdec_val[2*DATA_W-1:DATA_W];
            regs[a_lo] <= incdec_val[DATA_W-1:0];
            wrap_o     <= incdec_wrap;
          end
          OP_XCHG: if (a_ok && b_ok) begin
            xchg_tmp   <= pair_a_val;
            xchg_b     <= op_pair_b_i;
            regs[a_hi] <= pair_b_val[2*DATA_W-1:DATA_W];
            regs[a_lo] <= pair_b_val[DATA_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_val = rd_reg_ok  ? regs[rd_reg_i]   : '0;
  assign pair_val = rd_pair_ok ? pairs[rd_pair_i] : '0;

`ifdef RF_TRISTATE_RD_EN
  assign rd_byte_o = rd_byte_en_i ? byte_val : 'z;
  assign rd_pair_o = rd_pair_en_i ? pair_val : 'z;
`else
  assign rd_byte_o = rd_byte_en_i ? byte_val : '0;
  assign rd_pair_o = rd_pair_en_i ? pair_val : '0;
`endif

endmodule
